// File: rtl/dmd_pkg.sv
// Shared constants and the colour-mapping function for the DMD pixel engine.
package dmd_pkg;

  localparam int DEF_COLS = 128;
  localparam int DEF_ROWS = 32;
  localparam int DEF_BPP  = 4;
  localparam int DEF_BASE = 50;

  // base + level*step at 16 bits, saturated to 8 bits.
  function automatic logic [7:0] map_channel(input logic [7:0] base,
                                             input logic [7:0] level,
                                             input logic [7:0] step);
    logic [15:0] sum;
    sum = 16'(base) + 16'(level) * 16'(step);
    return (sum > 16'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/dmd_frame_ram.sv
// Two-bank frame store: simple dual-port RAM, 2*N words of BPP bits.
// Address MSB selects the bank; read data is registered (1-cycle latency).
module dmd_frame_ram #(
  parameter int N   = 4096,
  parameter int BPP = 4,
  parameter int AW  = 12
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW:0]    wr_addr,
  input  logic [BPP-1:0] wr_data,
  input  logic [AW:0]    rd_addr,
  output logic [BPP-1:0] rd_data
);

  logic [BPP-1:0] mem [0:2*N-1];
  logic [AW:0]    wr_idx;
  logic [AW:0]    rd_idx;

  // Map {bank, linear} onto the packed 2*N array (bank 1 starts at word N).
  always_comb begin
    wr_idx = wr_addr[AW] ? ((AW+1)'(N) + {1'b0, wr_addr[AW-1:0]}) : {1'b0, wr_addr[AW-1:0]};
    rd_idx = rd_addr[AW] ? ((AW+1)'(N) + {1'b0, rd_addr[AW-1:0]}) : {1'b0, rd_addr[AW-1:0]};
  end

  // Storage write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/dmd_pixel_engine.sv
// Double-buffered DMD pixel engine: host writes the back bank, the scan side
// reads the front bank through a fixed 3-stage pipeline, swaps on start of frame.
// Optional build macro DMD_BORDER_EN forces the frame border to full brightness.
module dmd_pixel_engine
  import dmd_pkg::*;
#(
  parameter  int COLS = DEF_COLS,
  parameter  int ROWS = DEF_ROWS,
  parameter  int BPP  = DEF_BPP,
  parameter  int BASE = DEF_BASE,
  localparam int AW   = $clog2(COLS*ROWS),
  localparam int XW   = $clog2(COLS),
  localparam int YW   = $clog2(ROWS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [AW-1:0]  wr_addr,
  input  logic [BPP-1:0] wr_data,
  output logic           wr_err,
  input  logic           swap_req,
  output logic           swap_done,
  input  logic           pix_valid,
  input  logic           pix_sof,
  input  logic [XW-1:0]  pix_x,
  input  logic [YW-1:0]  pix_y,
  input  logic [7:0]     step_r,
  input  logic [7:0]     step_g,
  input  logic [7:0]     step_b,
  output logic           o_valid,
  output logic [7:0]     o_r,
  output logic [7:0]     o_g,
  output logic [7:0]     o_b
);

  localparam logic [AW:0]    NPIX    = (AW+1)'(COLS*ROWS);
  localparam logic [XW:0]    COLS_W  = (XW+1)'(COLS);
  localparam logic [YW:0]    ROWS_W  = (YW+1)'(ROWS);
  localparam logic [BPP-1:0] LVL_MAX = '1;
  localparam logic [7:0]     BASE8   = 8'(BASE);

  logic           front;
  logic           swap_pending;
  logic           swap_now;
  logic           wr_fire;
  logic           wr_in_range;
  logic           pix_in_range;
  logic [AW-1:0]  pix_lin;

  logic           s1_valid, s1_oor, s1_bank;
  logic [AW-1:0]  s1_addr;
  logic           s2_valid, s2_oor;
  logic [BPP-1:0] ram_q;
  logic [BPP-1:0] level_eff;

  assign wr_ready     = !swap_pending;
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_in_range  = {1'b0, wr_addr} < NPIX;
  assign swap_now     = pix_valid && pix_sof && swap_pending;
  assign pix_in_range = ({1'b0, pix_x} < COLS_W) && ({1'b0, pix_y} < ROWS_W);
  assign pix_lin      = AW'(pix_y) * AW'(COLS) + AW'(pix_x);

  // Bank control, swap handshake and write-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      swap_done <= swap_now;
      wr_err    <= wr_fire && !wr_in_range;
      if (swap_now) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Stage 1: register address; the sof pixel of a swap already uses the new bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s1_bank  <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_oor   <= !pix_in_range;
      s1_bank  <= front ^ swap_now;
      s1_addr  <= pix_in_range ? pix_lin : '0;
    end
  end

  dmd_frame_ram #(.N(COLS*ROWS), .BPP(BPP), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (wr_fire && wr_in_range),
    .wr_addr ({~front, wr_addr}),
    .wr_data (wr_data),
    .rd_addr ({s1_bank, s1_addr}),
    .rd_data (ram_q)
  );

  // Stage 2: qualifiers travel alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_oor   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_oor   <= s1_oor;
    end
  end

`ifdef DMD_BORDER_EN
  logic pix_border;
  logic s1_border, s2_border;

  assign pix_border = pix_in_range &&
                      (pix_x == '0 || pix_x == XW'(COLS-1) ||
                       pix_y == '0 || pix_y == YW'(ROWS-1));

  // Border flag follows the pixel through stages 1 and 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_border <= 1'b0;
      s2_border <= 1'b0;
    end else begin
      s1_border <= pix_border;
      s2_border <= s1_border;
    end
  end

  // Effective level: out-of-range is black, border is full, else RAM.
  always_comb begin
    level_eff = ram_q;
    if (s2_oor)         level_eff = '0;
    else if (s2_border) level_eff = LVL_MAX;
  end
`else
  // Effective level: out-of-range is black, else RAM.
  always_comb begin
    level_eff = ram_q;
    if (s2_oor) level_eff = '0;
  end
`endif

  // Stage 3: colour map with steps sampled here; colour holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_r     <= 8'd0;
      o_g     <= 8'd0;
      o_b     <= 8'd0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_r <= map_channel(BASE8, 8'(level_eff), step_r);
        o_g <= map_channel(BASE8, 8'(level_eff), step_g);
        o_b <= map_channel(BASE8, 8'(level_eff), step_b);
      end
    end
  end

endmodule

// File: tb/tb_dmd_pixel_engine.sv
// Directed bench for dmd_pixel_engine: default instance plus a small
// non-power-of-two instance that can express out-of-range addresses.
module tb_dmd_pixel_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] step_r, step_g, step_b;

  // default instance (128x32, AW=12, XW=7, YW=5)
  logic        wr_valid, wr_ready, wr_err, swap_req, swap_done;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic        pix_valid, pix_sof;
  logic [6:0]  pix_x;
  logic [4:0]  pix_y;
  logic        o_valid;
  logic [7:0]  o_r, o_g, o_b;

  // small instance (10x3, AW=5, XW=4, YW=2)
  logic        d2_wr_valid, d2_wr_ready, d2_wr_err, d2_swap_req, d2_swap_done;
  logic [4:0]  d2_wr_addr;
  logic [3:0]  d2_wr_data;
  logic        d2_pix_valid, d2_pix_sof;
  logic [3:0]  d2_pix_x;
  logic [1:0]  d2_pix_y;
  logic        d2_o_valid;
  logic [7:0]  d2_o_r, d2_o_g, d2_o_b;

  dmd_pixel_engine dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .swap_req(swap_req), .swap_done(swap_done),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_x(pix_x), .pix_y(pix_y),
    .step_r(step_r), .step_g(step_g), .step_b(step_b),
    .o_valid(o_valid), .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  dmd_pixel_engine #(.COLS(10), .ROWS(3), .BPP(4), .BASE(50)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(d2_wr_valid), .wr_ready(d2_wr_ready), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
    .wr_err(d2_wr_err), .swap_req(d2_swap_req), .swap_done(d2_swap_done),
    .pix_valid(d2_pix_valid), .pix_sof(d2_pix_sof), .pix_x(d2_pix_x), .pix_y(d2_pix_y),
    .step_r(step_r), .step_g(step_g), .step_b(step_b),
    .o_valid(d2_o_valid), .o_r(d2_o_r), .o_g(d2_o_g), .o_b(d2_o_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wr2(input logic [4:0] a, input logic [3:0] d);
    d2_wr_valid = 1'b1; d2_wr_addr = a; d2_wr_data = d;
    tick();
    d2_wr_valid = 1'b0;
  endtask

  task automatic request_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_o_valid: got %0b expected 0", o_valid); end
    checks++; if (o_r !== 8'd0 || o_g !== 8'd0 || o_b !== 8'd0) begin errors++; $display("FAIL reset_rgb: got %0d/%0d/%0d expected 0/0/0", o_r, o_g, o_b); end
    checks++; if (wr_ready !== 1'b1)  begin errors++; $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); end
    checks++; if (swap_done !== 1'b0 || wr_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got swap_done=%0b wr_err=%0b expected 0/0", swap_done, wr_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_swap();
    step_r = 8'd13; step_g = 8'd13; step_b = 8'd13;
    wr(12'd0, 4'd15);
    wr(12'd1, 4'd3);
    request_swap();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL pending_wr_ready: got %0b expected 0", wr_ready); end
    pix_valid = 1'b1; pix_sof = 1'b1; pix_x = 7'd0; pix_y = 5'd0;
    tick();
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL swap_done_pulse: got %0b expected 1", swap_done); end
    checks++; if (wr_ready !== 1'b1)  begin errors++; $display("FAIL post_swap_wr_ready: got %0b expected 1", wr_ready); end
    pix_sof = 1'b0; pix_x = 7'd1;
    tick();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_single: got %0b expected 0", swap_done); end
    pix_valid = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b1 || o_r !== 8'd245 || o_g !== 8'd245 || o_b !== 8'd245) begin errors++; $display("FAIL lvl15_step13: got v=%0b %0d/%0d/%0d expected v=1 245/245/245", o_valid, o_r, o_g, o_b); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_r !== 8'd89) begin errors++; $display("FAIL back_to_back_lvl3: got v=%0b r=%0d expected v=1 r=89", o_valid, o_r); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_r !== 8'd89) begin errors++; $display("FAIL idle_hold: got v=%0b r=%0d expected v=0 r=89", o_valid, o_r); end
  endtask

  task automatic test_wr_ready_hold();
    request_swap();
    wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_wr_ready_%0d: got %0b expected 0", i, wr_ready); end
    end
    pix_valid = 1'b1; pix_sof = 1'b1; pix_x = 7'd0; pix_y = 5'd0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL sof_cycle_wr_ready: got %0b expected 0", wr_ready); end
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0;
    checks++; if (wr_ready !== 1'b1 || swap_done !== 1'b1) begin errors++; $display("FAIL after_sof: got ready=%0b done=%0b expected 1/1", wr_ready, swap_done); end
    tick();
    wr_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturate();
    step_r = 8'd20; step_g = 8'd13; step_b = 8'd0;
    wr(12'd2, 4'd15);
    request_swap();
    pix_valid = 1'b1; pix_sof = 1'b1; pix_x = 7'd2; pix_y = 5'd0;
    tick();
    pix_sof = 1'b0; pix_x = 7'd5;
    tick();
    pix_valid = 1'b0;
    tick();
    checks++; if (o_r !== 8'd255 || o_g !== 8'd245 || o_b !== 8'd50) begin errors++; $display("FAIL saturate_lvl15: got %0d/%0d/%0d expected 255/245/50", o_r, o_g, o_b); end
    tick();
    checks++; if (o_r !== 8'd190 || o_g !== 8'd141 || o_b !== 8'd50) begin errors++; $display("FAIL held_write_lvl7: got %0d/%0d/%0d expected 190/141/50", o_r, o_g, o_b); end
    tick();
  endtask

  task automatic test_border();
    logic [7:0] exp_edge;
`ifdef DMD_BORDER_EN
    exp_edge = 8'd245;
`else
    exp_edge = 8'd50;
`endif
    step_r = 8'd13; step_g = 8'd13; step_b = 8'd13;
    wr(12'd645, 4'd0);
    wr(12'd767, 4'd0);
    request_swap();
    pix_valid = 1'b1; pix_sof = 1'b1; pix_x = 7'd127; pix_y = 5'd5;
    tick();
    pix_sof = 1'b0; pix_x = 7'd5;
    tick();
    pix_valid = 1'b0;
    tick();
    checks++; if (o_r !== exp_edge || o_b !== exp_edge) begin errors++; $display("FAIL pixel_127_5: got %0d/%0d expected %0d", o_r, o_b, exp_edge); end
    tick();
    checks++; if (o_r !== 8'd50 || o_g !== 8'd50) begin errors++; $display("FAIL pixel_5_5: got %0d/%0d expected 50", o_r, o_g); end
    tick();
  endtask

  task automatic test_out_of_range();
    step_r = 8'd13; step_g = 8'd13; step_b = 8'd13;
    wr2(5'd0, 4'd4);
    wr2(5'd29, 4'd11);
    checks++; if (d2_wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_inrange: got %0b expected 0", d2_wr_err); end
    wr2(5'd30, 4'd9);
    checks++; if (d2_wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_pulse: got %0b expected 1", d2_wr_err); end
    tick();
    checks++; if (d2_wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_once: got %0b expected 0", d2_wr_err); end
    d2_swap_req = 1'b1; tick(); d2_swap_req = 1'b0;
    d2_pix_valid = 1'b1; d2_pix_sof = 1'b1; d2_pix_x = 4'd0; d2_pix_y = 2'd0;
    tick();
    checks++; if (d2_swap_done !== 1'b1) begin errors++; $display("FAIL d2_swap_done: got %0b expected 1", d2_swap_done); end
    d2_pix_sof = 1'b0; d2_pix_x = 4'd9; d2_pix_y = 2'd2;
    tick();
    d2_pix_x = 4'd12; d2_pix_y = 2'd0;
    tick();
    checks++; if (d2_o_valid !== 1'b1 || d2_o_r !== 8'd102) begin errors++; $display("FAIL d2_addr0: got v=%0b r=%0d expected v=1 r=102", d2_o_valid, d2_o_r); end
    d2_pix_x = 4'd0; d2_pix_y = 2'd3;
    tick();
    checks++; if (d2_o_r !== 8'd193) begin errors++; $display("FAIL d2_addr29: got %0d expected 193", d2_o_r); end
    d2_pix_valid = 1'b0;
    tick();
    checks++; if (d2_o_r !== 8'd50 || d2_o_g !== 8'd50) begin errors++; $display("FAIL d2_x_oor: got %0d/%0d expected 50", d2_o_r, d2_o_g); end
    tick();
    checks++; if (d2_o_valid !== 1'b1 || d2_o_r !== 8'd50) begin errors++; $display("FAIL d2_y_oor: got v=%0b r=%0d expected v=1 r=50", d2_o_valid, d2_o_r); end
    tick();
  endtask

  task automatic test_reset_pending();
    step_r = 8'd13; step_g = 8'd13; step_b = 8'd13;
    wr(12'd645, 4'd9);
    request_swap();
    pix_valid = 1'b1; pix_sof = 1'b0; pix_x = 7'd5; pix_y = 5'd5;
    tick(); tick(); tick();
    checks++; if (o_valid !== 1'b1 || o_r !== 8'd50) begin errors++; $display("FAIL pre_reset_stream: got v=%0b r=%0d expected v=1 r=50", o_valid, o_r); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_r !== 8'd0 || o_g !== 8'd0 || o_b !== 8'd0) begin errors++; $display("FAIL async_reset_out: got v=%0b %0d/%0d/%0d expected 0", o_valid, o_r, o_g, o_b); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_cancels_pending: got ready=%0b expected 1", wr_ready); end
    pix_sof = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL no_swap_after_reset: got %0b expected 0", swap_done); end
    pix_sof = 1'b0; pix_valid = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL resume_latency_early: got %0b expected 0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_r !== 8'd50) begin errors++; $display("FAIL front_bank0_after_reset: got v=%0b r=%0d expected v=1 r=50", o_valid, o_r); end
  endtask

  initial begin
    rst_n = 1'b0;
    step_r = 8'd0; step_g = 8'd0; step_b = 8'd0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_x = '0; pix_y = '0;
    d2_wr_valid = 1'b0; d2_wr_addr = '0; d2_wr_data = '0; d2_swap_req = 1'b0;
    d2_pix_valid = 1'b0; d2_pix_sof = 1'b0; d2_pix_x = '0; d2_pix_y = '0;
    test_reset();
    test_write_swap();
    test_wr_ready_hold();
    test_saturate();
    test_border();
    test_out_of_range();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
